// File: rtl/fetch_pkg.sv
// Shared types for the Hack CPU instruction fetch front-end.
// Queue depth and the {instr, pc} entry carried from ROM to decode.
package fetch_pkg;

    localparam int FETCH_WIDTH  = 16;
    localparam int FETCH_DWIDTH = 16;

    localparam logic [1:0] FETCH_QDEPTH = 2'd2;

    typedef struct packed {
        logic [FETCH_DWIDTH-1:0] instr;
        logic [FETCH_WIDTH-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetched instructions.
// Head is a register; flush wins over push; push+pop legal when full.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t tail;

    // Entry storage and occupancy; pop shifts tail into head
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (count == FETCH_QDEPTH) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= din;
                    end else begin
                        tail <= din;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch front-end: owns the fetch PC, issues ROM reads on credit,
// buffers returned words and handles redirects from execute.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int WIDTH  = FETCH_WIDTH,
    parameter int DWIDTH = FETCH_DWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    output logic              rom_en,
    output logic [WIDTH-1:0]  rom_addr,
    input  logic [DWIDTH-1:0] rom_data,
    input  logic              redirect,
    input  logic [WIDTH-1:0]  redirect_addr,
    output logic [DWIDTH-1:0] instr,
    output logic [WIDTH-1:0]  instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    logic [WIDTH-1:0] fpc;
    logic [WIDTH-1:0] inflight_pc;
    logic [WIDTH-1:0] issue_addr;
    logic             inflight;
    logic             issue;
    logic             pop;
    logic             push;
    logic [1:0]       count;
    logic [1:0]       occ;
    fetch_entry_t     din;
    fetch_entry_t     head;

    // Credit: queued words plus the word still coming back from ROM
    assign occ = count + {1'b0, inflight};

    assign instr_valid = (count != 2'd0) && !redirect;
    assign pop         = instr_valid && instr_ready;
    assign push        = inflight && !redirect;

    assign issue = redirect
                 || (occ < FETCH_QDEPTH)
                 || ((occ == FETCH_QDEPTH) && pop);

    assign issue_addr = redirect ? redirect_addr : fpc;
    assign rom_en     = issue && !reset;
    assign rom_addr   = reset ? '0 : issue_addr;

    assign instr    = head.instr;
    assign instr_pc = head.pc;

    // Response word is tagged with the address it was fetched from
    always_comb begin
        din       = '0;
        din.instr = rom_data;
        din.pc    = inflight_pc;
    end

    // Fetch PC and in-flight tracking; PC wraps modulo 2^WIDTH
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc         <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (issue) begin
            fpc         <= issue_addr + WIDTH'(1);
            inflight    <= 1'b1;
            inflight_pc <= issue_addr;
        end else begin
            inflight    <= 1'b0;
        end
    end

    fetch_queue u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queue-based reference model.
// ROM model returns address ^ 0xA5A5 one cycle after rom_en.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    typedef struct {
        logic [15:0] i;
        logic [15:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_fpc;
    logic [15:0] m_ipc;
    bit          m_infl;
    bit          m_fresh;
    bit          m_known;

    logic        s_valid;
    logic        s_en;
    logic [15:0] s_addr;
    logic [15:0] s_pc;
    logic [15:0] s_instr;

    int checks;
    int errors;

    instr_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .rom_en        (rom_en),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_addr ^ 16'hA5A5;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rd,
                        input logic [15:0] ra, input logic rdy);
        int   n;
        bit   mpop;
        bit   e_valid;
        bit   e_en;
        logic [15:0] e_addr;
        reset         = r;
        redirect      = rd;
        redirect_addr = ra;
        instr_ready   = rdy;
        @(negedge clk);
        s_valid = instr_valid;
        s_en    = rom_en;
        s_addr  = rom_addr;
        s_pc    = instr_pc;
        s_instr = instr;
        n       = mq.size();
        e_valid = (n > 0) && !rd;
        mpop    = e_valid && rdy;
        e_en    = !r && (rd || (n + int'(m_infl) < 2)
                  || (n + int'(m_infl) == 2 && mpop));
        e_addr  = r ? 16'h0000 : (rd ? ra : m_fpc);
        if (m_known) begin
            chk("valid", {31'd0, s_valid}, {31'd0, e_valid});
            chk("rom_en", {31'd0, s_en}, {31'd0, e_en});
            if (e_en || r) chk("rom_addr", {16'd0, s_addr}, {16'd0, e_addr});
            if (e_valid) begin
                chk("instr_pc", {16'd0, s_pc}, {16'd0, mq[0].pc});
                chk("instr", {16'd0, s_instr}, {16'd0, mq[0].i});
            end else if (m_fresh && n == 0) begin
                chk("empty_pc", {16'd0, s_pc}, 32'd0);
                chk("empty_instr", {16'd0, s_instr}, 32'd0);
            end
        end
        if (r) begin
            mq.delete();
            m_infl  = 0;
            m_fpc   = 16'h0000;
            m_fresh = 1;
            m_known = 1;
        end else begin
            if (rd) begin
                mq.delete();
            end else begin
                if (mpop) void'(mq.pop_front());
                if (m_infl) begin
                    mq.push_back('{i: m_ipc ^ 16'hA5A5, pc: m_ipc});
                    m_fresh = 0;
                end
            end
            if (e_en) begin
                m_infl = 1;
                m_ipc  = e_addr;
                m_fpc  = e_addr + 16'd1;
            end else begin
                m_infl = 0;
            end
        end
        chk("model_depth", {31'd0, mq.size() > 2}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        m_known       = 0;
        m_fresh       = 0;
        m_infl        = 0;
        m_fpc         = 16'h0000;
        m_ipc         = 16'h0000;
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_addr = 16'h0000;
        instr_ready   = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("rst_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_en", {31'd0, s_en}, 32'd0);
        chk("rst_addr", {16'd0, s_addr}, 32'd0);

        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("start_en", {31'd0, s_en}, 32'd1);
        chk("start_addr", {16'd0, s_addr}, 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("c2_addr", {16'd0, s_addr}, 32'd1);
        chk("c2_valid", {31'd0, s_valid}, 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("first_valid", {31'd0, s_valid}, 32'd1);
        chk("first_pc", {16'd0, s_pc}, 32'h0000);
        chk("first_instr", {16'd0, s_instr}, 32'hA5A5);
        repeat (5) step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("c8_pc", {16'd0, s_pc}, 32'd5);

        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("bp_en", {31'd0, s_en}, 32'd0);
        repeat (5) step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("bp_en_hold", {31'd0, s_en}, 32'd0);
        chk("bp_pc_hold", {16'd0, s_pc}, 32'd6);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("rel_pc6", {16'd0, s_pc}, 32'd6);
        chk("rel_addr", {16'd0, s_addr}, 32'd8);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("rel_pc7", {16'd0, s_pc}, 32'd7);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("rel_pc8", {16'd0, s_pc}, 32'd8);

        repeat (2) step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h0100, 1'b1);
        chk("redir_valid", {31'd0, s_valid}, 32'd0);
        chk("redir_addr", {16'd0, s_addr}, 32'h0100);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("redir_gap", {31'd0, s_valid}, 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("redir_pc0", {16'd0, s_pc}, 32'h0100);
        chk("redir_i0", {16'd0, s_instr}, 32'hA4A5);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("redir_pc1", {16'd0, s_pc}, 32'h0101);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("redir_pc2", {16'd0, s_pc}, 32'h0102);

        step(1'b0, 1'b1, 16'hFFFF, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("wrap_pc0", {16'd0, s_pc}, 32'hFFFF);
        chk("wrap_i0", {16'd0, s_instr}, 32'h5A5A);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("wrap_pc1", {16'd0, s_pc}, 32'h0000);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("wrap_pc2", {16'd0, s_pc}, 32'h0001);

        step(1'b0, 1'b1, 16'h0200, 1'b1);
        chk("rr_valid", {31'd0, s_valid}, 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("rr_pc", {16'd0, s_pc}, 32'h0200);
        chk("rr_instr", {16'd0, s_instr}, 32'hA7A5);

        repeat (2) step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("mrst_en", {31'd0, s_en}, 32'd0);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("mrst_valid", {31'd0, s_valid}, 32'd0);
        chk("mrst_en2", {31'd0, s_en}, 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("restart_addr", {16'd0, s_addr}, 32'd0);
        chk("restart_en", {31'd0, s_en}, 32'd1);
        repeat (2) step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("restart_pc", {16'd0, s_pc}, 32'd0);
        chk("restart_instr", {16'd0, s_instr}, 32'hA5A5);
        repeat (4) step(1'b0, 1'b0, 16'h0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
